// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, data-memory geometry.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int unsigned MEM_WORDS = 128;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StLdata,
        StMerge,
        StWr,
        StResp
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the load/store unit: load extract/extend, store merge and alignment check.
// Store merge is only present when LSU_RMW_EN is defined.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_signed,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic        bad,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'h00;
        unique case (lane)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
        endcase
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: load_data = {{24{is_signed & byte_v[7]}}, byte_v};
            SZ_HALF: load_data = {{16{is_signed & half_v[15]}}, half_v};
            default: load_data = rdata;
        endcase
    end

    assign bad = (size == SZ_RSVD)
              || (size == SZ_HALF && lane[0])
              || (size == SZ_WORD && lane != 2'd0);

`ifdef LSU_RMW_EN
    always_comb begin
        merge_data = rdata;
        case (size)
            SZ_BYTE: begin
                unique case (lane)
                    2'd0: merge_data[7:0]   = wdata[7:0];
                    2'd1: merge_data[15:8]  = wdata[7:0];
                    2'd2: merge_data[23:16] = wdata[7:0];
                    2'd3: merge_data[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) merge_data[31:16] = wdata[15:0];
                else         merge_data[15:0]  = wdata[15:0];
            end
            SZ_WORD: merge_data = wdata;
            default: merge_data = rdata;
        endcase
    end
`else
    logic unused_wdata;
    assign unused_wdata = ^wdata;
    assign merge_data   = '0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: byte-addressed requests to a word-addressed synchronous data memory.
// Define LSU_RMW_EN to enable sub-word stores via read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = $clog2(MEM_WORDS) + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [31:0]       mem_rdata
);

`ifdef LSU_RMW_EN
    localparam logic RmwEn = 1'b1;
`else
    localparam logic RmwEn = 1'b0;
`endif

    lsu_state_e  state;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        signed_q;
    logic        write_q;
    logic [31:0] wdata_q;

    logic [1:0]  a_size;
    logic [1:0]  a_lane;
    logic        a_bad;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        accept;
    logic        req_err;

    // The alignment check runs on the incoming request in IDLE, on latched fields otherwise.
    assign a_size = (state == StIdle) ? req_size      : size_q;
    assign a_lane = (state == StIdle) ? req_addr[1:0] : lane_q;

    lsu_align u_align (
        .size       (a_size),
        .lane       (a_lane),
        .is_signed  (signed_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .bad        (a_bad),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    assign accept  = req_valid && req_ready;
    assign req_err = a_bad || (!RmwEn && req_write && req_size != SZ_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
            size_q     <= SZ_BYTE;
            lane_q     <= 2'd0;
            signed_q   <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
        end else begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        size_q    <= req_size;
                        lane_q    <= req_addr[1:0];
                        signed_q  <= req_signed;
                        write_q   <= req_write;
                        wdata_q   <= req_wdata;
                        mem_addr  <= req_addr[ADDR_W-1:2];
                        if (req_err) begin
                            state      <= StResp;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_write && req_size == SZ_WORD) begin
                            state     <= StWr;
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= StRd;
                            mem_read <= 1'b1;
                        end
                    end
                end
                StRd: begin
                    state <= (RmwEn && write_q) ? StMerge : StLdata;
                end
                StLdata: begin
                    state      <= StResp;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_data;
                end
`ifdef LSU_RMW_EN
                StMerge: begin
                    state     <= StWr;
                    mem_write <= 1'b1;
                    mem_wdata <= merge_data;
                end
`endif
                StWr: begin
                    state      <= StResp;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                StResp: begin
                    state      <= StIdle;
                    req_ready  <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: begin
                    state     <= StIdle;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a synchronous 128x32 memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata)
    );

    // Memory model; the preload port avoids mixing bench writes with the clocked writes.
    logic [31:0] mem [0:127];
    logic        pl_en = 1'b0;
    logic [6:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (pl_en)     mem[pl_addr]  <= pl_data;
        if (mem_read)  mem_rdata     <= mem[mem_addr];
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          rd_off;
        int          wr_off;
        logic [6:0]  waddr;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_rd = 0;
    int   n_wr = 0;
    int   rd_off = -1;
    int   wr_off = -1;
    int   resp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic err, input logic [31:0] rdata, input int lat,
                                input int rd, input int wr, input logic [6:0] waddr);
        exp_t e;
        e.err = err; e.rdata = rdata; e.lat = lat;
        e.rd_off = rd; e.wr_off = wr; e.waddr = waddr;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if ((mem_read || mem_write) && sb.size() > 0)
                check("mem_addr", 32'(mem_addr), 32'(sb[0].waddr));
            if (mem_read) begin
                n_rd++;
                rd_off = cyc - acc_cyc;
            end
            if (mem_write) begin
                n_wr++;
                wr_off = cyc - acc_cyc;
            end
            if (resp_valid) begin
                resp_cnt++;
                if (sb.size() == 0) begin
                    check("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("latency", cyc - acc_cyc, e.lat);
                    check("read_cycle", rd_off, e.rd_off);
                    check("write_cycle", wr_off, e.wr_off);
                    check("read_count", n_rd, (e.rd_off >= 0) ? 1 : 0);
                    check("write_count", n_wr, (e.wr_off >= 0) ? 1 : 0);
                end
            end
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                n_rd = 0;
                n_wr = 0;
                rd_off = -1;
                wr_off = -1;
            end
        end
    end

    // All driver tasks start and end at posedge + #1.
    task automatic preload(input logic [6:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [8:0] addr, input logic [31:0] wd, input exp_t e);
        int k = 0;
        wait_ready();
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (sb.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            check("resp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int k;
        int rc;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_WORD;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        k = 0;
        while (!req_ready && k < 5) begin
            @(posedge clk); #1;
            k++;
        end
        check("ready_after_rst", 32'(req_ready), 32'd1);
        check("ready_after_rst_cycles", k, 1);

        // Word store then word load.
        do_req(1'b1, SZ_WORD, 1'b0, 9'h034, 32'hDEADBEEF, mk(1'b0, 32'h0, 2, -1, 1, 7'd13));
        check("sw_mem", mem[13], 32'hDEADBEEF);
        do_req(1'b0, SZ_WORD, 1'b0, 9'h034, 32'h0, mk(1'b0, 32'hDEADBEEF, 3, 1, -1, 7'd13));

        // Sub-word loads with sign/zero extension.
        preload(7'd13, 32'h80817F03);
        do_req(1'b0, SZ_BYTE, 1'b1, 9'h037, 32'h0, mk(1'b0, 32'hFFFFFF80, 3, 1, -1, 7'd13));
        do_req(1'b0, SZ_BYTE, 1'b0, 9'h037, 32'h0, mk(1'b0, 32'h00000080, 3, 1, -1, 7'd13));
        do_req(1'b0, SZ_HALF, 1'b1, 9'h034, 32'h0, mk(1'b0, 32'h00007F03, 3, 1, -1, 7'd13));
        do_req(1'b0, SZ_HALF, 1'b0, 9'h036, 32'h0, mk(1'b0, 32'h00008081, 3, 1, -1, 7'd13));
        do_req(1'b0, SZ_HALF, 1'b1, 9'h036, 32'h0, mk(1'b0, 32'hFFFF8081, 3, 1, -1, 7'd13));
        do_req(1'b0, SZ_BYTE, 1'b1, 9'h034, 32'h0, mk(1'b0, 32'h00000003, 3, 1, -1, 7'd13));

        // Sub-word stores.
        preload(7'd13, 32'h11223344);
`ifdef LSU_RMW_EN
        do_req(1'b1, SZ_BYTE, 1'b0, 9'h035, 32'h000000AA, mk(1'b0, 32'h0, 4, 1, 3, 7'd13));
        check("sb_mem", mem[13], 32'h1122AA44);
        do_req(1'b1, SZ_HALF, 1'b0, 9'h036, 32'h00001234, mk(1'b0, 32'h0, 4, 1, 3, 7'd13));
        check("sh_mem", mem[13], 32'h1234AA44);
`else
        do_req(1'b1, SZ_BYTE, 1'b0, 9'h035, 32'h000000AA, mk(1'b1, 32'h0, 1, -1, -1, 7'd13));
        do_req(1'b1, SZ_HALF, 1'b0, 9'h034, 32'h00001234, mk(1'b1, 32'h0, 1, -1, -1, 7'd13));
        check("no_rmw_mem", mem[13], 32'h11223344);
        do_req(1'b0, SZ_HALF, 1'b1, 9'h034, 32'h0, mk(1'b0, 32'h00003344, 3, 1, -1, 7'd13));
`endif

        // Misaligned and reserved-size requests.
        preload(7'd13, 32'hCAFEF00D);
        do_req(1'b0, SZ_WORD, 1'b0, 9'h036, 32'h0, mk(1'b1, 32'h0, 1, -1, -1, 7'd13));
        do_req(1'b1, SZ_HALF, 1'b0, 9'h035, 32'h00001234, mk(1'b1, 32'h0, 1, -1, -1, 7'd13));
        do_req(1'b0, SZ_RSVD, 1'b0, 9'h034, 32'h0, mk(1'b1, 32'h0, 1, -1, -1, 7'd13));
        do_req(1'b1, SZ_RSVD, 1'b0, 9'h034, 32'h12345678, mk(1'b1, 32'h0, 1, -1, -1, 7'd13));
        check("err_mem", mem[13], 32'hCAFEF00D);

        // Reset in the cycle after the read: MERGE for a store, LDATA for a load.
        preload(7'd13, 32'h55667788);
        wait_ready();
        rc = resp_cnt;
`ifdef LSU_RMW_EN
        req_write = 1'b1; req_size = SZ_BYTE;
`else
        req_write = 1'b0; req_size = SZ_WORD;
`endif
        req_valid = 1'b1; req_signed = 1'b0; req_addr = 9'h034; req_wdata = 32'h00000099;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("rst_abort_no_write", n_wr, 0);
        check("rst_abort_no_resp", resp_cnt, rc);
        check("rst_abort_mem", mem[13], 32'h55667788);
        check("rst_abort_ready", 32'(req_ready), 32'd1);
        do_req(1'b0, SZ_WORD, 1'b0, 9'h034, 32'h0, mk(1'b0, 32'h55667788, 3, 1, -1, 7'd13));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
